// File: rtl/column_assembler_if.sv
// Bus bundle for column_assembler: SPI byte stream in, display read port out.
// Handshake: byte_flag is a level from the SPI receiver; each 0->1 edge carries one new byte_data, no ready/backpressure.
interface column_assembler_if #(parameter int ADDR_W = 10);
   logic              cs;
   logic [7:0]        byte_data;
   logic              byte_flag;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       rd_data;
   logic              frame_done;
   logic              frame_err;
   logic [2:0]        dbg_state;

   modport master (
      output cs, byte_data, byte_flag, rd_addr,
      input  rd_data, frame_done, frame_err, dbg_state
   );

   modport slave (
      input  cs, byte_data, byte_flag, rd_addr,
      output rd_data, frame_done, frame_err, dbg_state
   );
endinterface

// File: rtl/column_assembler.sv
// Assembles SPI bytes into 16-bit column words of a frame and serves them to the display.
// COLUMN_DOUBLE_BUFFER_EN selects two swapped banks; otherwise one shared bank.
module column_assembler #(
   parameter int NUM_COLS = 640,
   parameter int ADDR_W   = 10
) (
   input  logic clk,
   input  logic rst,
   column_assembler_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HI     = 3'd1,
      LO     = 3'd2,
      FULL   = 3'd3,
      COMMIT = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COLS - 1);
   localparam logic [ADDR_W:0]   COLS_EXT = (ADDR_W + 1)'(NUM_COLS);

   state_t            state, state_nxt;
   logic              cs_m, cs_s, cs_d, flag_d, armed;
   logic [1:0]        sync_vld;
   logic              byte_ev, cs_rise, cs_fall, start;
   logic [ADDR_W-1:0] word_idx;
   logic [7:0]        hi_byte;
   logic              err;
   logic              wr_en, done_c;
   logic [15:0]       wr_data;
   logic              rd_in_range;

   // armed only goes high once the synchronizer holds a real, high cs sample,
   // so a cs already low when reset releases never starts a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_m     <= 1'b1;
         cs_s     <= 1'b1;
         cs_d     <= 1'b1;
         flag_d   <= 1'b0;
         sync_vld <= 2'b00;
         armed    <= 1'b0;
      end else begin
         cs_m     <= bus.cs;
         cs_s     <= cs_m;
         cs_d     <= cs_s;
         flag_d   <= bus.byte_flag;
         sync_vld <= {sync_vld[0], 1'b1};
         if (sync_vld[1] && cs_s) armed <= 1'b1;
      end
   end

   assign byte_ev = bus.byte_flag & ~flag_d;
   assign cs_rise = ~cs_d & cs_s;
   assign cs_fall = cs_d & ~cs_s;
   assign start   = cs_fall & armed;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = HI;
         HI: begin
            if (cs_rise)      state_nxt = IDLE;
            else if (byte_ev) state_nxt = LO;
         end
         LO: begin
            if (cs_rise)      state_nxt = IDLE;
            else if (byte_ev) state_nxt = (word_idx == LAST_IDX) ? FULL : HI;
         end
         FULL:   if (cs_rise) state_nxt = COMMIT;
         COMMIT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_en  = 1'b0;
      done_c = 1'b0;
      if (!rst) begin
         case (state)
            LO:      wr_en  = byte_ev & ~cs_rise;
            COMMIT:  done_c = 1'b1;
            default: ;
         endcase
      end
   end

   assign wr_data = {hi_byte, bus.byte_data};

   // A cs rise wins over a coincident byte: the byte is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx <= '0;
         hi_byte  <= 8'h00;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               word_idx <= '0;
               err      <= 1'b0;
            end
            HI: begin
               if (cs_rise)      err     <= 1'b1;
               else if (byte_ev) hi_byte <= bus.byte_data;
            end
            LO: begin
               if (cs_rise) err <= 1'b1;
               else if (byte_ev && word_idx != LAST_IDX) word_idx <= word_idx + 1'b1;
            end
            FULL: if (!cs_rise && byte_ev) err <= 1'b1;
            default: ;
         endcase
      end
   end

   assign rd_in_range    = {1'b0, bus.rd_addr} < COLS_EXT;
   assign bus.frame_done = done_c;
   assign bus.frame_err  = err;
   assign bus.dbg_state  = state;

`ifdef COLUMN_DOUBLE_BUFFER_EN
   // bank_sel names the displayed bank; writes land in the other one.
   logic        bank_sel;
   logic [15:0] mem0 [NUM_COLS];
   logic [15:0] mem1 [NUM_COLS];

   always_ff @(posedge clk) begin
      if (rst)                   bank_sel <= 1'b0;
      else if (state == COMMIT)  bank_sel <= ~bank_sel;
   end

   always_ff @(posedge clk) begin
      if (wr_en && bank_sel)  mem0[word_idx] <= wr_data;
      if (wr_en && !bank_sel) mem1[word_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)               bus.rd_data <= 16'h0000;
      else if (!rd_in_range) bus.rd_data <= 16'h0000;
      else                   bus.rd_data <= bank_sel ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
   end
`else
   logic [15:0] mem [NUM_COLS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[word_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)               bus.rd_data <= 16'h0000;
      else if (!rd_in_range) bus.rd_data <= 16'h0000;
      else                   bus.rd_data <= mem[bus.rd_addr];
   end
`endif

endmodule

// File: doc/column_assembler.md
COLUMN_ASSEMBLER -- requirements
Module: column_assembler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 640, meaning the number of 16-bit column words per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the column address width; it SHALL satisfy 2^ADDR_W >= NUM_COLS.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cs, input, 1 bit: raw SPI chip-select pin, active-low, asynchronous to clk.
REQ-006 SHALL have port byte_data, input, 8 bits: the last byte assembled by the SPI receiver.
REQ-007 SHALL have port byte_flag, input, 1 bit: the receiver's byte-complete level, which stays high for many clk cycles after each byte.
REQ-008 SHALL have port rd_addr, input, ADDR_W bits: display-side column read address.
REQ-009 SHALL have port rd_data, output, 16 bits: column word read from rd_addr.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a complete frame is committed.
REQ-011 SHALL have port frame_err, output, 1 bit: sticky flag for a short or overlong frame.

Function
REQ-012 SHALL pass cs through a 2-flop synchronizer; cs_s denotes the synchronized value.
REQ-013 SHALL treat only a 0->1 transition of byte_flag (registered compare) as one byte event, so each byte is consumed exactly once.
REQ-014 SHALL implement the states IDLE, HI, LO, FULL and COMMIT.
REQ-015 IDLE: on cs_s falling, SHALL clear word_idx to 0 and go to HI; byte events SHALL be ignored while in IDLE.
REQ-016 HI: on a byte event SHALL latch byte_data as bits [15:8] and go to LO.
REQ-017 LO: on a byte event SHALL write {hi, byte_data} to the write bank at word_idx in that same cycle.
REQ-018 After that write, if word_idx = NUM_COLS-1 SHALL go to FULL; otherwise SHALL increment word_idx and return to HI.
REQ-019 FULL: byte events SHALL NOT write memory; the first such byte event SHALL set frame_err (overrun).
REQ-020 In any of HI, LO or FULL, cs_s rising SHALL go to COMMIT if the state is FULL, otherwise to IDLE with frame_err set (short frame, incl. dangling high byte).
REQ-021 A short frame SHALL NOT swap banks.
REQ-022 COMMIT: for exactly one cycle SHALL assert frame_done, toggle the bank select, then go to IDLE.
REQ-023 frame_err SHALL clear on the next cs_s falling edge that starts a frame.
REQ-024 A byte event and cs_s rising in the same cycle SHALL be resolved in favour of cs_s; that byte is dropped.
REQ-025 rd_data SHALL be registered, one-cycle latency, from the display bank; rd_addr >= NUM_COLS SHALL return 16'h0000.
REQ-026 Memory SHALL be synchronous single-write/single-read per bank, inferable as block RAM.

Reset
REQ-027 rst SHALL force state IDLE, word_idx 0, bank select 0, frame_done 0, frame_err 0, rd_data 16'h0000, and the edge/sync registers to idle values (cs high, byte_flag low).
REQ-028 rst mid-frame SHALL abandon the frame with no swap and no frame_done; memory contents are not cleared.
REQ-029 After rst, a frame starting while cs_s is still low SHALL NOT be accepted until cs_s has been seen high.

Configuration
REQ-030 With macro COLUMN_DOUBLE_BUFFER_EN defined, SHALL instantiate two banks of NUM_COLS words; writes go to the bank opposite the display bank, and COMMIT swaps them.
REQ-031 Without COLUMN_DOUBLE_BUFFER_EN, SHALL use a single bank for both writes and reads, so the display may see partially written frames; COMMIT still pulses frame_done, and the bank-select logic is absent.

Verification
REQ-032 Reset, then cs low, send 1280 bytes where word i = i, then cs high -> frame_done exactly once, frame_err 0, and rd_addr 5 yields 0x0005 one cycle later.
REQ-033 Hold byte_flag high for 20 clks per byte over one word 0xABCD -> exactly one write of 0xABCD at index 0, with no duplicate.
REQ-034 Send 1281 bytes -> frame_err 1 after byte 1281, frame_done still pulses on cs rise, and word 639 is unchanged by the extra byte.
REQ-035 Send 100 bytes, then cs high -> frame_err 1, no frame_done, and display data still equals the previous frame (double-buffer build).
REQ-036 Assert rst during byte 600 of a frame, then send a full frame -> that frame commits normally, and rd_addr 700 returns 0x0000.
REQ-037 Run two full frames (values i, then 0xFFFF-i) in both builds -> with the macro, rd_data matches the last committed frame throughout the next transfer; without it, rd_data tracks the in-progress writes.
